// File: rtl/rfid_rx_pkg.sv
// rfid_rx_pkg: shared state encodings, rate codes and window timing tables for the RX window controller.
package rfid_rx_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOLDOFF = 3'd1,
    SEARCH  = 3'd2,
    RECEIVE = 3'd3,
    DONE    = 3'd4
  } rx_state_t;
  typedef enum logic [2:0] {
    RATE_64K  = 3'd0,
    RATE_137K = 3'd1,
    RATE_175K = 3'd2,
    RATE_320K = 3'd3,
    RATE_128K = 3'd4,
    RATE_274K = 3'd5,
    RATE_349K = 3'd6,
    RATE_640K = 3'd7
  } rx_rate_t;
  localparam int HOLD_MUL = 16;
  localparam int WIN_MUL  = 64;
  // Backscatter half-period in clock cycles, indexed by rate code (index 0 is the rightmost entry).
  localparam logic [7:0][7:0] P_TAB = {8'd20, 8'd36, 8'd46, 8'd98, 8'd39, 8'd72, 8'd91, 8'd195};
  function automatic int half_period(input logic [2:0] r);
    return int'(P_TAB[r]);
  endfunction
endpackage

// File: rtl/rx_win_timer.sv
// rx_win_timer: loadable down-counter that saturates at 1 and flags expiry when it reads 1.
module rx_win_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] value_o,
  output logic             expire_o
);
  logic [CNT_W-1:0] r_value;
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) r_value <= '0;
    else if (clr_i) r_value <= '0;
    else if (load_i) r_value <= load_val_i;
    else if (en_i && r_value > CNT_W'(1)) r_value <= r_value - CNT_W'(1);
  end
  assign value_o  = r_value;
  assign expire_o = r_value == CNT_W'(1);
endmodule

// File: rtl/rx_window_ctrl.sv
// rx_window_ctrl: sequences the post-command holdoff, preamble search and frame receive windows
// for an RFID reader receiver, emitting one registered result pulse per window.
module rx_window_ctrl
  import rfid_rx_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             tx_done_i,
  input  logic [2:0]       set_rate_i,
  input  logic [CNT_W-1:0] frame_max_i,
  input  logic             abort_i,
  input  logic             wave_enable_i,
  input  logic             frame_done_i,
  input  logic             frame_err_i,
  output logic             det_rst_o,
  output logic [2:0]       rate_o,
  output logic             busy_o,
  output logic             ok_o,
  output logic             err_o,
  output logic             timeout_o,
  output logic [2:0]       state_o
);
  rx_state_t        r_state, w_nxt;
  logic [2:0]       r_rate;
  logic             r_ok, r_err, r_to;
  logic             w_ok, w_err, w_to;
  logic             w_ld, w_en, w_clr, w_expire, w_start;
  logic [CNT_W-1:0] w_ld_val, w_timer;
  rx_win_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i      (clk_i),
    .rst        (rst),
    .clr_i      (w_clr),
    .load_i     (w_ld),
    .load_val_i (w_ld_val),
    .en_i       (w_en),
    .value_o    (w_timer),
    .expire_o   (w_expire)
  );
  assign w_start = r_state == IDLE && tx_done_i && !abort_i;
  always_comb begin
    w_nxt    = r_state;
    w_ld     = 1'b0;
    w_ld_val = '0;
    w_en     = 1'b0;
    w_clr    = 1'b0;
    w_ok     = 1'b0;
    w_err    = 1'b0;
    w_to     = 1'b0;
    if (abort_i) begin
      w_nxt = IDLE;
      w_clr = 1'b1;
    end else begin
      case (r_state)
        IDLE: if (tx_done_i) begin
          w_nxt    = HOLDOFF;
          w_ld     = 1'b1;
          w_ld_val = CNT_W'(HOLD_MUL * half_period(set_rate_i));
        end
        HOLDOFF: begin
          w_en = 1'b1;
          if (w_expire) begin
            w_nxt    = SEARCH;
            w_ld     = 1'b1;
            w_ld_val = CNT_W'(WIN_MUL * half_period(r_rate));
          end
        end
        SEARCH: begin
          w_en = 1'b1;
          if (wave_enable_i) begin
            w_nxt    = RECEIVE;
            w_ld     = 1'b1;
            w_ld_val = frame_max_i;
          end else if (w_expire) begin
            w_nxt = DONE;
            w_to  = 1'b1;
          end
        end
        RECEIVE: begin
          // An unlimited frame (frame_max_i == 0) freezes the timer and never times out.
          w_en = frame_max_i != '0 && w_timer != '0;
          if (frame_err_i) begin
            w_nxt = DONE;
            w_err = 1'b1;
          end else if (frame_done_i) begin
            w_nxt = DONE;
            w_ok  = 1'b1;
          end else if (frame_max_i != '0 && w_expire) begin
            w_nxt = DONE;
            w_to  = 1'b1;
          end
        end
        default: w_nxt = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_rate  <= '0;
      r_ok    <= 1'b0;
      r_err   <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_ok    <= w_ok;
      r_err   <= w_err;
      r_to    <= w_to;
      if (w_start) r_rate <= set_rate_i;
    end
  end
  assign det_rst_o = !(r_state == SEARCH || r_state == RECEIVE);
  assign busy_o    = r_state != IDLE;
  assign rate_o    = r_rate;
  assign ok_o      = r_ok;
  assign err_o     = r_err;
  assign timeout_o = r_to;
  assign state_o   = r_state;
endmodule

// File: tb/tb_rx_window_ctrl.sv
// tb_rx_window_ctrl: directed windows with a result-pulse scoreboard drained by an independent monitor.
module tb_rx_window_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic        tx_done = 1'b0, abort = 1'b0, wave = 1'b0, fdone = 1'b0, ferr = 1'b0;
  logic [2:0]  set_rate = 3'd0;
  logic [15:0] frame_max = 16'd0;
  logic        det_rst, busy, ok, err, tmo;
  logic [2:0]  rate, state;
  int          cyc = 0, n_chk = 0, n_pass = 0, c0 = 0;
  typedef struct {logic [2:0] kind; int at;} exp_t;
  exp_t        sb[$];
  exp_t        mon_e;

  rx_window_ctrl #(.CNT_W(16)) dut (
    .clk_i         (clk),
    .rst           (rst),
    .tx_done_i     (tx_done),
    .set_rate_i    (set_rate),
    .frame_max_i   (frame_max),
    .abort_i       (abort),
    .wave_enable_i (wave),
    .frame_done_i  (fdone),
    .frame_err_i   (ferr),
    .det_rst_o     (det_rst),
    .rate_o        (rate),
    .busy_o        (busy),
    .ok_o          (ok),
    .err_o         (err),
    .timeout_o     (tmo),
    .state_o       (state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, req, cyc);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Returns on the first HOLDOFF cycle; set_rate is then changed to prove the latch holds.
  task automatic start(input int r);
    set_rate = 3'(r);
    tx_done  = 1'b1;
    tick();
    tx_done  = 1'b0;
    set_rate = 3'(7 - r);
    chk("start_holdoff", int'(state), 1);
    chk("start_rate_latched", int'(rate), r);
  endtask

  task automatic expect_res(input logic [2:0] k, input int at);
    sb.push_back('{k, at});
  endtask

  // Result codes are {ok, err, timeout}.
  initial forever begin
    @(negedge clk);
    if (!rst && (ok || err || tmo)) begin
      if (sb.size() == 0) chk("unexpected_result", int'({ok, err, tmo}), 0);
      else begin
        mon_e = sb.pop_front();
        chk("result_kind", int'({ok, err, tmo}), int'(mon_e.kind));
        chk("result_cycle", cyc, mon_e.at);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    tick(2);
    chk("rst_state", int'(state), 0);
    chk("rst_det_rst", int'(det_rst), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rate", int'(rate), 0);
    chk("rst_results", int'({ok, err, tmo}), 0);
    rst = 1'b0;
    tick(2);

    // rate 0: 3120 HOLDOFF cycles, then SEARCH with detector released
    start(0);
    chk("t1_det_rst_holdoff", int'(det_rst), 1);
    tick(3119);
    chk("t1_last_holdoff", int'(state), 1);
    tick();
    chk("t1_search", int'(state), 2);
    chk("t1_det_rst_search", int'(det_rst), 0);
    chk("t1_rate_held", int'(rate), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t1_abort_idle", int'(state), 0);

    // rate 7: wave in HOLDOFF ignored, tx_done while busy and in DONE dropped, timeout at +1600
    start(7);
    c0 = cyc;
    expect_res(3'b001, c0 + 1600);
    wave = 1'b1;
    tick(100);
    wave = 1'b0;
    chk("t2_wave_ignored", int'(state), 1);
    tick(300);
    chk("t2_search", int'(state), 2);
    tx_done  = 1'b1;
    set_rate = 3'd0;
    tick();
    tx_done  = 1'b0;
    chk("t2_txdone_busy_ignored", int'(state), 2);
    chk("t2_rate_kept", int'(rate), 7);
    tick(1199);
    chk("t2_done", int'(state), 4);
    chk("t2_done_det_rst", int'(det_rst), 1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("t2_idle_after_done", int'(state), 0);
    chk("t2_busy_low", int'(busy), 0);

    // rate 3: wave at SEARCH cycle 100, frame_done 200 cycles later -> ok
    frame_max = 16'd500;
    start(3);
    tick(624);
    chk("t3_search", int'(state), 2);
    tick(100);
    wave = 1'b1;
    tick();
    wave = 1'b0;
    chk("t3_receive", int'(state), 3);
    tick(199);
    fdone = 1'b1;
    expect_res(3'b100, cyc + 1);
    tick();
    fdone = 1'b0;
    chk("t3_done", int'(state), 4);
    tick();
    chk("t3_idle", int'(state), 0);

    // unlimited frame: timer frozen, then done+err together -> err wins
    frame_max = 16'd0;
    start(7);
    tick(320);
    wave = 1'b1;
    tick();
    wave = 1'b0;
    chk("t4_receive", int'(state), 3);
    tick(3000);
    chk("t4_no_timeout", int'(state), 3);
    fdone = 1'b1;
    ferr  = 1'b1;
    expect_res(3'b010, cyc + 1);
    tick();
    fdone = 1'b0;
    ferr  = 1'b0;
    chk("t4_done", int'(state), 4);
    tick();

    // wave on the SEARCH expiry cycle wins, then a 50-cycle frame limit times out
    frame_max = 16'd50;
    start(7);
    c0 = cyc;
    tick(1599);
    wave = 1'b1;
    tick();
    wave = 1'b0;
    chk("t5_receive_on_expiry", int'(state), 3);
    expect_res(3'b001, c0 + 1650);
    tick(50);
    chk("t5_done", int'(state), 4);
    tick();

    // abort in RECEIVE: straight to IDLE, no result
    frame_max = 16'd0;
    start(7);
    tick(320);
    wave = 1'b1;
    tick();
    wave = 1'b0;
    chk("t6_receive", int'(state), 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t6_abort_state", int'(state), 0);
    chk("t6_abort_det_rst", int'(det_rst), 1);
    chk("t6_abort_busy", int'(busy), 0);
    tick(20);
    chk("t6_stays_idle", int'(state), 0);

    // rst mid-SEARCH: asynchronous clear, needs a fresh tx_done afterwards
    start(5);
    tick(836);
    chk("t7_search", int'(state), 2);
    #2 rst = 1'b1;
    #1;
    chk("t7_rst_state", int'(state), 0);
    chk("t7_rst_det_rst", int'(det_rst), 1);
    chk("t7_rst_rate", int'(rate), 0);
    chk("t7_rst_busy", int'(busy), 0);
    tick();
    rst = 1'b0;
    tick(50);
    chk("t7_idle_after_rst", int'(state), 0);
    start(7);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    tick(5);
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
